// File: rtl/debug_bridge_pkg.sv
// Shared constants and FSM state type for the debug memory bridge.
// Opcodes, response codes and the frame sequencer states.
package debug_bridge_pkg;

  localparam logic [7:0] OP_WR_IRAM = 8'h01;
  localparam logic [7:0] OP_RD_IRAM = 8'h02;
  localparam logic [7:0] OP_WR_DRAM = 8'h03;
  localparam logic [7:0] OP_RD_DRAM = 8'h04;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/dbg_resp_shifter.sv
// Response register: loads up to 4 bytes, emits them LSB first
// over a valid/ready byte handshake.
module dbg_resp_shifter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        done_o
);

  logic [31:0] sh_q, sh_d;
  logic [2:0]  n_q, n_d;
  logic        fire;

  always_comb begin
    sh_d   = sh_q;
    n_d    = n_q;
    fire   = (n_q != 3'd0) && tx_ready_i;
    done_o = fire && (n_q == 3'd1);
    if (load_i) begin
      sh_d = data_i;
      n_d  = nbytes_i;
    end else if (fire) begin
      sh_d = {8'h00, sh_q[31:8]};
      n_d  = n_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q <= '0;
      n_q  <= '0;
    end else begin
      sh_q <= sh_d;
      n_q  <= n_d;
    end
  end

  assign tx_data_o  = sh_q[7:0];
  assign tx_valid_o = (n_q != 3'd0);

endmodule

// File: rtl/debug_mem_bridge.sv
// Byte-stream debug master for the InstRAM/DataRAM second ports.
// Decodes framed commands, performs one word access, returns a response.
module debug_mem_bridge
  import debug_bridge_pkg::*;
#(
  parameter int RD_LATENCY     = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] CPU_Debug_InstRAM_A2,
  output logic [31:0] CPU_Debug_InstRAM_WD2,
  output logic [3:0]  CPU_Debug_InstRAM_WE2,
  input  logic [31:0] CPU_Debug_InstRAM_RD2,
  output logic [31:0] CPU_Debug_DataRAM_A2,
  output logic [31:0] CPU_Debug_DataRAM_WD2,
  output logic [3:0]  CPU_Debug_DataRAM_WE2,
  input  logic [31:0] CPU_Debug_DataRAM_RD2,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LATENCY - 1);

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           wr_q, wr_d;
  logic           dsel_q, dsel_d;
  logic [TW-1:0]  to_q, to_d;
  logic [LW-1:0]  lat_q, lat_d;

  logic           rx_fire;
  logic           ld;
  logic [31:0]    ld_data;
  logic [2:0]     ld_n;
  logic           tx_done;

  assign rx_ready = CPU_RST && ((state_q == S_IDLE) ||
                               (state_q == S_ADDR) ||
                               (state_q == S_DATA));
  assign rx_fire  = rx_valid && rx_ready;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    dsel_d  = dsel_q;
    to_d    = '0;
    lat_d   = '0;
    ld      = 1'b0;
    ld_data = '0;
    ld_n    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          cnt_d   = '0;
          state_d = S_ADDR;
          unique case (rx_data)
            OP_WR_IRAM: begin wr_d = 1'b1; dsel_d = 1'b0; end
            OP_RD_IRAM: begin wr_d = 1'b0; dsel_d = 1'b0; end
            OP_WR_DRAM: begin wr_d = 1'b1; dsel_d = 1'b1; end
            OP_RD_DRAM: begin wr_d = 1'b0; dsel_d = 1'b1; end
            default: begin
              ld      = 1'b1;
              ld_data = {24'h0, RESP_ERR};
              ld_n    = 3'd1;
              state_d = S_RESP;
            end
          endcase
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          addr_d = {rx_data, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = wr_q ? S_DATA : S_ACCESS;
        end else begin
          to_d = to_q + 1'b1;
          if (to_q == TO_LAST) state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          wdata_d = {rx_data, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_ACCESS;
        end else begin
          to_d = to_q + 1'b1;
          if (to_q == TO_LAST) state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (wr_q) begin
          ld      = 1'b1;
          ld_data = {24'h0, RESP_ACK};
          ld_n    = 3'd1;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          ld      = 1'b1;
          ld_data = dsel_q ? CPU_Debug_DataRAM_RD2
                           : CPU_Debug_InstRAM_RD2;
          ld_n    = 3'd4;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_RESP: begin
        if (tx_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      dsel_q  <= 1'b0;
      to_q    <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      dsel_q  <= dsel_d;
      to_q    <= to_d;
      lat_q   <= lat_d;
    end
  end

  logic        drive, wr_cyc;
  logic [31:0] maddr;

  // Only the selected port moves, and only while the access is live.
  always_comb begin
    drive  = (state_q == S_ACCESS) || (state_q == S_WAIT);
    wr_cyc = (state_q == S_ACCESS) && wr_q;
    maddr  = addr_q & 32'hFFFF_FFFC;
    CPU_Debug_InstRAM_A2  = (drive && !dsel_q) ? maddr : '0;
    CPU_Debug_InstRAM_WD2 = (wr_cyc && !dsel_q) ? wdata_q : '0;
    CPU_Debug_InstRAM_WE2 = (wr_cyc && !dsel_q) ? 4'hF : 4'h0;
    CPU_Debug_DataRAM_A2  = (drive && dsel_q) ? maddr : '0;
    CPU_Debug_DataRAM_WD2 = (wr_cyc && dsel_q) ? wdata_q : '0;
    CPU_Debug_DataRAM_WE2 = (wr_cyc && dsel_q) ? 4'hF : 4'h0;
  end

  dbg_resp_shifter u_resp (
    .clk_i      (CPU_CLK),
    .rst_ni     (CPU_RST),
    .load_i     (ld),
    .data_i     (ld_data),
    .nbytes_i   (ld_n),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .done_o     (tx_done)
  );

endmodule

// File: tb/tb_debug_mem_bridge.sv
// Directed bench for debug_mem_bridge: one instance at RD_LATENCY=1,
// a second at RD_LATENCY=3, both with an 8-cycle frame timeout.
module tb_debug_mem_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, rx_ready, tx_valid, tx_ready, busy;
  logic [31:0] i_a2, i_wd2, i_rd, d_a2, d_wd2, d_rd;
  logic [3:0]  i_we, d_we;

  logic [7:0]  r1_data, t1_data;
  logic        r1_valid, r1_ready, t1_valid, t1_ready, busy1;
  logic [31:0] j_a2, j_wd2, j_rd, e_a2, e_wd2, e_rd;
  logic [3:0]  j_we, e_we;
  logic [31:0] j_p1, j_p2;

  int errors = 0;
  int checks = 0;
  int iwe_n = 0;
  int dwe_n = 0;
  int txv_n = 0;

  debug_mem_bridge #(.RD_LATENCY(1), .TIMEOUT_CYCLES(8)) dut (
    .CPU_CLK(clk), .CPU_RST(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .CPU_Debug_InstRAM_A2(i_a2), .CPU_Debug_InstRAM_WD2(i_wd2),
    .CPU_Debug_InstRAM_WE2(i_we), .CPU_Debug_InstRAM_RD2(i_rd),
    .CPU_Debug_DataRAM_A2(d_a2), .CPU_Debug_DataRAM_WD2(d_wd2),
    .CPU_Debug_DataRAM_WE2(d_we), .CPU_Debug_DataRAM_RD2(d_rd),
    .busy(busy)
  );

  debug_mem_bridge #(.RD_LATENCY(3), .TIMEOUT_CYCLES(8)) dut3 (
    .CPU_CLK(clk), .CPU_RST(rst_n),
    .rx_data(r1_data), .rx_valid(r1_valid), .rx_ready(r1_ready),
    .tx_data(t1_data), .tx_valid(t1_valid), .tx_ready(t1_ready),
    .CPU_Debug_InstRAM_A2(j_a2), .CPU_Debug_InstRAM_WD2(j_wd2),
    .CPU_Debug_InstRAM_WE2(j_we), .CPU_Debug_InstRAM_RD2(j_rd),
    .CPU_Debug_DataRAM_A2(e_a2), .CPU_Debug_DataRAM_WD2(e_wd2),
    .CPU_Debug_DataRAM_WE2(e_we), .CPU_Debug_DataRAM_RD2(e_rd),
    .busy(busy1)
  );

  // RAM read models: InstRAM returns ~addr; DataRAM holds 0x12345678 at 0x20.
  always @(posedge clk) begin
    i_rd <= ~i_a2;
    d_rd <= (d_a2 == 32'h20) ? 32'h12345678 : ~d_a2;
    j_p1 <= ~j_a2;
    j_p2 <= j_p1;
    j_rd <= j_p2;
    e_rd <= ~e_a2;
  end

  always @(negedge clk) begin
    if (i_we != 4'h0) iwe_n = iwe_n + 1;
    if (d_we != 4'h0) dwe_n = dwe_n + 1;
    if (tx_valid) txv_n = txv_n + 1;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready byte=%h rx_ready=%b want 1", b, rx_ready);
    end
    @(posedge clk);
  endtask

  // Called at a negedge; accepts up to nmax bytes, returns at the negedge
  // after the last accepted byte.
  task automatic drain(input int nmax, output logic [31:0] w,
                       output int n);
    w = '0;
    n = 0;
    tx_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (n >= nmax) break;
      if (tx_valid) begin
        w[n*8 +: 8] = tx_data;
        n++;
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl rx_ready=%b busy=%b want 0 0",
               rx_ready, busy);
    end
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx valid=%b data=%h want 0 00",
               tx_valid, tx_data);
    end
    checks++;
    if ({i_a2, i_wd2, i_we, d_a2, d_wd2, d_we} !== '0) begin
      errors++;
      $display("FAIL reset_ram i_a2=%h d_a2=%h i_we=%h d_we=%h want 0",
               i_a2, d_a2, i_we, d_we);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release rx_ready=%b want 1", rx_ready);
    end
  endtask

  task automatic test_write_iram();
    logic [31:0] w;
    int n;
    int we0;
    we0 = iwe_n;
    send(8'h01); send(8'h10); send(8'h00); send(8'h00); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (i_we !== 4'hF || i_a2 !== 32'h10 || i_wd2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_iram_port we=%h a2=%h wd2=%h want F 10 deadbeef",
               i_we, i_a2, i_wd2);
    end
    checks++;
    if ({d_a2, d_wd2, d_we} !== '0) begin
      errors++;
      $display("FAIL wr_iram_dram_idle a2=%h wd2=%h we=%h want 0",
               d_a2, d_wd2, d_we);
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_iram_early_tx tx_valid=%b want 0", tx_valid);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL wr_iram_ack valid=%b data=%h want 1 a5",
               tx_valid, tx_data);
    end
    checks++;
    if (i_we !== 4'h0 || i_a2 !== 32'h0) begin
      errors++;
      $display("FAIL wr_iram_release we=%h a2=%h want 0 0", i_we, i_a2);
    end
    drain(1, w, n);
    checks++;
    if (rx_ready !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_iram_idle rx_ready=%b busy=%b tx_valid=%b want 1 0 0",
               rx_ready, busy, tx_valid);
    end
    checks++;
    if (iwe_n - we0 != 1) begin
      errors++;
      $display("FAIL wr_iram_we_cycles got=%0d want 1", iwe_n - we0);
    end
  endtask

  task automatic test_read_dram();
    logic [31:0] w;
    logic [7:0]  pd;
    logic        pend;
    int got;
    send(8'h04); send(8'h22); send(8'h00); send(8'h00); send(8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (d_a2 !== 32'h20 || d_we !== 4'h0 || i_a2 !== 32'h0) begin
      errors++;
      $display("FAIL rd_dram_access d_a2=%h d_we=%h i_a2=%h want 20 0 0",
               d_a2, d_we, i_a2);
    end
    @(negedge clk);
    checks++;
    if (d_a2 !== 32'h20 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_dram_wait d_a2=%h tx_valid=%b want 20 0",
               d_a2, tx_valid);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h78 || d_a2 !== 32'h0) begin
      errors++;
      $display("FAIL rd_dram_first valid=%b data=%h a2=%h want 1 78 0",
               tx_valid, tx_data, d_a2);
    end
    w = '0;
    got = 0;
    pend = 1'b0;
    pd = '0;
    for (int k = 0; k < 40; k++) begin
      if (got >= 4) break;
      tx_ready = (k % 2 == 1);
      if (tx_valid) begin
        if (pend) begin
          checks++;
          if (tx_data !== pd) begin
            errors++;
            $display("FAIL rd_dram_stable data=%h want %h", tx_data, pd);
          end
        end
        if (tx_ready) begin
          w[got*8 +: 8] = tx_data;
          got++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          pd = tx_data;
        end
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    checks++;
    if (got != 4 || w !== 32'h12345678) begin
      errors++;
      $display("FAIL rd_dram_data got=%0d word=%h want 4 12345678", got, w);
    end
    checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_dram_idle busy=%b rx_ready=%b want 0 1",
               busy, rx_ready);
    end
  endtask

  task automatic test_bad_opcode();
    logic [31:0] w;
    int n;
    send(8'h7F);
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hEE || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL bad_op_resp valid=%b data=%h rx_ready=%b want 1 ee 0",
               tx_valid, tx_data, rx_ready);
    end
    drain(1, w, n);
    checks++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_op_idle rx_ready=%b busy=%b want 1 0",
               rx_ready, busy);
    end
    send(8'h02); send(8'h40); send(8'h00); send(8'h00); send(8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (i_a2 !== 32'h40 || i_we !== 4'h0) begin
      errors++;
      $display("FAIL bad_op_next_a2 a2=%h we=%h want 40 0", i_a2, i_we);
    end
    repeat (2) @(negedge clk);
    drain(4, w, n);
    checks++;
    if (n != 4 || w !== 32'hFFFFFFBF) begin
      errors++;
      $display("FAIL bad_op_next_data n=%0d word=%h want 4 ffffffbf", n, w);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    int n;
    int we0, tv0, hi;
    we0 = iwe_n + dwe_n;
    tv0 = txv_n;
    send(8'h03); send(8'h00); send(8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      hi++;
      @(negedge clk);
    end
    checks++;
    if (hi != 8) begin
      errors++;
      $display("FAIL timeout_len busy_cycles=%0d want 8", hi);
    end
    checks++;
    if (iwe_n + dwe_n != we0 || txv_n != tv0) begin
      errors++;
      $display("FAIL timeout_quiet we=%0d tx=%0d want %0d %0d",
               iwe_n + dwe_n, txv_n, we0, tv0);
    end
    send(8'h03); send(8'h24); send(8'h00); send(8'h00); send(8'h00);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (d_we !== 4'hF || d_a2 !== 32'h24 || d_wd2 !== 32'h11223344) begin
      errors++;
      $display("FAIL timeout_next_wr we=%h a2=%h wd2=%h want F 24 11223344",
               d_we, d_a2, d_wd2);
    end
    checks++;
    if ({i_a2, i_wd2, i_we} !== '0) begin
      errors++;
      $display("FAIL timeout_next_iram a2=%h we=%h want 0", i_a2, i_we);
    end
    @(negedge clk);
    drain(1, w, n);
    checks++;
    if (n != 1 || w[7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL timeout_next_ack n=%0d data=%h want 1 a5", n, w[7:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int we0;
    we0 = iwe_n + dwe_n;
    send(8'h01); send(8'h00); send(8'h01); send(8'h00); send(8'h00);
    send(8'hAA);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctl busy=%b rx_ready=%b tx_valid=%b want 0 0 0",
               busy, rx_ready, tx_valid);
    end
    checks++;
    if ({i_a2, i_wd2, i_we, d_a2, d_wd2, d_we, tx_data} !== '0) begin
      errors++;
      $display("FAIL midrst_outs i_a2=%h i_we=%h tx_data=%h want 0",
               i_a2, i_we, tx_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || iwe_n + dwe_n != we0) begin
      errors++;
      $display("FAIL midrst_after rx_ready=%b we=%0d want 1 %0d",
               rx_ready, iwe_n + dwe_n, we0);
    end
  endtask

  task automatic test_rd_latency3();
    logic [7:0]  fr [5];
    logic [31:0] w;
    int lat, n;
    fr[0] = 8'h02; fr[1] = 8'h20; fr[2] = 8'h00;
    fr[3] = 8'h00; fr[4] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      r1_valid = 1'b1;
      r1_data  = fr[i];
      @(posedge clk);
    end
    @(negedge clk);
    r1_valid = 1'b0;
    checks++;
    if (j_a2 !== 32'h20 || e_a2 !== 32'h0) begin
      errors++;
      $display("FAIL lat3_a2 a2=%h d_a2=%h want 20 0", j_a2, e_a2);
    end
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      if (t1_valid) break;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 5 || t1_data !== 8'hDF) begin
      errors++;
      $display("FAIL lat3_first cycle=N+%0d data=%h want N+5 df",
               lat, t1_data);
    end
    w = '0;
    n = 0;
    t1_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (n >= 4) break;
      if (t1_valid) begin
        w[n*8 +: 8] = t1_data;
        n++;
      end
      @(negedge clk);
    end
    t1_ready = 1'b0;
    checks++;
    if (n != 4 || w !== 32'hFFFFFFDF || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL lat3_data n=%0d word=%h busy=%b want 4 ffffffdf 0",
               n, w, busy1);
    end
  endtask

  initial begin
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    r1_data = '0; r1_valid = 1'b0; t1_ready = 1'b0;
    test_reset();
    test_write_iram();
    test_read_dram();
    test_bad_opcode();
    test_timeout();
    test_reset_mid_frame();
    test_rd_latency3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
